// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one fifo_mem write port among NREQ producers
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = 5,
  parameter int IW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic               pause_i,
  input  logic               fifo_pop_i,
  input  logic               fifo_overflow_i,
  output logic               fifo_wr_o,
  output logic [DW-1:0]      fifo_data_o,
  output logic [IW-1:0]      fifo_src_o,
  output logic [CW-1:0]      occupancy_o,
  output logic               err_overflow_o,
  output logic               err_underflow_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_C  = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_C  = (IW+1)'(NREQ);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          fifo_wr_q, fifo_wr_d;
  logic [DW-1:0] fifo_data_q, fifo_data_d;
  logic [IW-1:0] fifo_src_q, fifo_src_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;

  logic          grant_en;
  logic          found;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   scan_sum;
  logic          accept;
  logic          pop_ok;

  // A pop in the same cycle never frees a slot for a grant: only the registered count matters.
  assign grant_en = !rst_i && !pause_i && (occ_q < DEPTH_C);

  // Scan from the requester after the last winner, wrapping modulo NREQ; first valid one wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan_sum >= NREQ_C) begin
        scan_sum = scan_sum - NREQ_C;
      end
      if (!found && req_valid_i[scan_sum[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan_sum[IW-1:0];
      end
    end
  end

  assign accept      = grant_en && found;
  assign req_ready_o = accept ? (NREQ'(1) << grant_idx) : '0;
  assign pop_ok      = fifo_pop_i && (occ_q != '0);

  // Next-state: register the winner's byte, advance the pointer, track occupancy and sticky errors.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    fifo_src_d  = fifo_src_q;
    occ_d       = occ_q;
    err_ovf_d   = err_ovf_q || fifo_overflow_i;
    err_unf_d   = err_unf_q || (fifo_pop_i && (occ_q == '0));
    if (accept) begin
      fifo_wr_d   = 1'b1;
      fifo_data_d = req_data_i[grant_idx*DW +: DW];
      fifo_src_d  = grant_idx;
      rr_ptr_d    = grant_idx;
    end
    if (accept && !pop_ok) begin
      occ_d = occ_q + CW'(1);
    end else if (!accept && pop_ok) begin
      occ_d = occ_q - CW'(1);
    end
  end

  // State register; reset puts the pointer on the last index so requester 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= LAST_C;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      fifo_src_q  <= '0;
      occ_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
      fifo_src_q  <= fifo_src_d;
      occ_q       <= occ_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign fifo_wr_o       = fifo_wr_q;
  assign fifo_data_o     = fifo_data_q;
  assign fifo_src_o      = fifo_src_q;
  assign occupancy_o     = occ_q;
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_unf_q;

endmodule
